alu_giris_asamasi: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU in the RISC-V core. It latches decoded instructions through a valid/ready handshake and selects the ALU operands: register, immediate or PC. It resolves data hazards by forwarding from the MEM and WB stages and stalls on load-use. It drives the ALU's `a`, `b` and `alu_dnt` inputs.

---
 rtl/alu_giris_asamasi.sv | 214 +++++++++++++++++++++
 tb/tb_alu_giris_asamasi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_giris_asamasi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_giris_asamasi                                               |
// | Purpose  : ID/EX stage in front of the ALU. Holds one decoded instruction  |
// |            behind a valid/ready handshake and selects the ALU operands.   |
// |            It forwards results from MEM/WB and stalls on load-use hazards. |
// | Config   : ALU_YONLENDIRME_EN - when defined, operands are forwarded from  |
// |            MEM/WB. When undefined, any pending producer stalls the stage   |
// |            until WB retires it.                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_giris_asamasi #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            temizle,
  input  logic            id_gecerli,
  output logic            id_hazir,
  input  logic [4:0]      id_rs1_adr,
  input  logic [4:0]      id_rs2_adr,
  input  logic [4:0]      id_rd_adr,
  input  logic [XLEN-1:0] id_rs1_deger,
  input  logic [XLEN-1:0] id_rs2_deger,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_imm_sec,
  input  logic            id_pc_sec,
  input  logic [3:0]      id_alu_dnt,
  input  logic            id_yaz_en,
  input  logic            id_yukle,
  input  logic            mem_yaz_en,
  input  logic [4:0]      mem_rd_adr,
  input  logic [XLEN-1:0] mem_sonuc,
  input  logic            mem_yukle,
  input  logic            wb_yaz_en,
  input  logic [4:0]      wb_rd_adr,
  input  logic [XLEN-1:0] wb_sonuc,
  output logic            ex_gecerli,
  input  logic            ex_hazir,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_dnt,
  output logic [XLEN-1:0] ex_rs2_deger,
  output logic [4:0]      ex_rd_adr,
  output logic            ex_yaz_en,
  output logic            ex_yukle,
  output logic [XLEN-1:0] ex_pc
);

  // Holding register (current and next-state)
  logic            gecerli_q,   gecerli_d;
  logic [4:0]      rs1_adr_q,   rs1_adr_d;
  logic [4:0]      rs2_adr_q,   rs2_adr_d;
  logic [4:0]      rd_adr_q,    rd_adr_d;
  logic [XLEN-1:0] rs1_deger_q, rs1_deger_d;
  logic [XLEN-1:0] rs2_deger_q, rs2_deger_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic            imm_sec_q,   imm_sec_d;
  logic            pc_sec_q,    pc_sec_d;
  logic [3:0]      alu_dnt_q,   alu_dnt_d;
  logic            yaz_en_q,    yaz_en_d;
  logic            yukle_q,     yukle_d;

  // Operand views: what EX sees (ileri) and what is written back while held (tazele)
  logic [XLEN-1:0] rs1_ileri, rs2_ileri;
  logic [XLEN-1:0] rs1_tazele, rs2_tazele;
  logic            durma;
  logic            rs1_kullan;
  logic            yakala;
  logic            aktarim;

  // A PC-relative instruction never reads rs1; rs2 is always read (store data).
  assign rs1_kullan = !pc_sec_q;

`ifdef ALU_YONLENDIRME_EN
  logic mem_isabet1, mem_isabet2, wb_isabet1, wb_isabet2;

  // A loading MEM instruction has no result yet, so it is never a forwarding source.
  assign mem_isabet1 = mem_yaz_en & !mem_yukle & (mem_rd_adr == rs1_adr_q);
  assign mem_isabet2 = mem_yaz_en & !mem_yukle & (mem_rd_adr == rs2_adr_q);
  assign wb_isabet1  = wb_yaz_en & (wb_rd_adr == rs1_adr_q);
  assign wb_isabet2  = wb_yaz_en & (wb_rd_adr == rs2_adr_q);

  // The youngest producer (MEM) wins over WB; x0 is hard-wired to zero.
  assign rs1_ileri = (rs1_adr_q == 5'd0) ? '0 :
                     mem_isabet1 ? mem_sonuc :
                     wb_isabet1  ? wb_sonuc  : rs1_deger_q;
  assign rs2_ileri = (rs2_adr_q == 5'd0) ? '0 :
                     mem_isabet2 ? mem_sonuc :
                     wb_isabet2  ? wb_sonuc  : rs2_deger_q;

  assign rs1_tazele = rs1_ileri;
  assign rs2_tazele = rs2_ileri;

  // Only a load in MEM forces a bubble; its data comes from WB one cycle later.
  assign durma = gecerli_q & mem_yaz_en & mem_yukle & (mem_rd_adr != 5'd0) &
                 (((mem_rd_adr == rs1_adr_q) & rs1_kullan) | (mem_rd_adr == rs2_adr_q));
`else
  logic mem_bagimli, wb_bagimli;
  logic unused_mem;

  // Without bypass paths the MEM result and its load flag have no consumer here.
  assign unused_mem = ^{mem_sonuc, mem_yukle};

  assign rs1_ileri = (rs1_adr_q == 5'd0) ? '0 : rs1_deger_q;
  assign rs2_ileri = (rs2_adr_q == 5'd0) ? '0 : rs2_deger_q;

  // WB results are still captured into the held entry so a stall can end.
  assign rs1_tazele = (wb_yaz_en & (wb_rd_adr == rs1_adr_q) & (rs1_adr_q != 5'd0)) ?
                      wb_sonuc : rs1_deger_q;
  assign rs2_tazele = (wb_yaz_en & (wb_rd_adr == rs2_adr_q) & (rs2_adr_q != 5'd0)) ?
                      wb_sonuc : rs2_deger_q;

  assign mem_bagimli = mem_yaz_en & (mem_rd_adr != 5'd0) &
                       (((mem_rd_adr == rs1_adr_q) & rs1_kullan) | (mem_rd_adr == rs2_adr_q));
  assign wb_bagimli  = wb_yaz_en & (wb_rd_adr != 5'd0) &
                       (((wb_rd_adr == rs1_adr_q) & rs1_kullan) | (wb_rd_adr == rs2_adr_q));

  // Any in-flight producer of a used source blocks issue.
  assign durma = gecerli_q & (mem_bagimli | wb_bagimli);
`endif

  // Handshakes
  assign ex_gecerli = gecerli_q & !durma;
  assign aktarim    = ex_gecerli & ex_hazir;
  assign id_hazir   = !gecerli_q | aktarim;
  assign yakala     = id_gecerli & id_hazir;

  // Operand selection and pass-through fields
  assign alu_a        = pc_sec_q  ? pc_q  : rs1_ileri;
  assign alu_b        = imm_sec_q ? imm_q : rs2_ileri;
  assign ex_rs2_deger = rs2_ileri;
  assign alu_dnt      = alu_dnt_q;
  assign ex_rd_adr    = rd_adr_q;
  assign ex_yaz_en    = yaz_en_q;
  assign ex_yukle     = yukle_q;
  assign ex_pc        = pc_q;

  // Next state of the holding register: flush, capture, drain or refresh in place.
  always_comb begin
    gecerli_d   = gecerli_q;
    rs1_adr_d   = rs1_adr_q;
    rs2_adr_d   = rs2_adr_q;
    rd_adr_d    = rd_adr_q;
    rs1_deger_d = rs1_deger_q;
    rs2_deger_d = rs2_deger_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    imm_sec_d   = imm_sec_q;
    pc_sec_d    = pc_sec_q;
    alu_dnt_d   = alu_dnt_q;
    yaz_en_d    = yaz_en_q;
    yukle_d     = yukle_q;
    if (temizle) begin
      gecerli_d = 1'b0;
    end else if (yakala) begin
      gecerli_d   = 1'b1;
      rs1_adr_d   = id_rs1_adr;
      rs2_adr_d   = id_rs2_adr;
      rd_adr_d    = id_rd_adr;
      rs1_deger_d = id_rs1_deger;
      rs2_deger_d = id_rs2_deger;
      imm_d       = id_imm;
      pc_d        = id_pc;
      imm_sec_d   = id_imm_sec;
      pc_sec_d    = id_pc_sec;
      alu_dnt_d   = id_alu_dnt;
      yaz_en_d    = id_yaz_en;
      yukle_d     = id_yukle;
    end else if (aktarim) begin
      gecerli_d = 1'b0;
    end else if (gecerli_q) begin
      rs1_deger_d = rs1_tazele;
      rs2_deger_d = rs2_tazele;
    end
  end

  // State register; reset discards the held instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gecerli_q   <= 1'b0;
      rs1_adr_q   <= 5'd0;
      rs2_adr_q   <= 5'd0;
      rd_adr_q    <= 5'd0;
      rs1_deger_q <= '0;
      rs2_deger_q <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      imm_sec_q   <= 1'b0;
      pc_sec_q    <= 1'b0;
      alu_dnt_q   <= 4'b0000;
      yaz_en_q    <= 1'b0;
      yukle_q     <= 1'b0;
    end else begin
      gecerli_q   <= gecerli_d;
      rs1_adr_q   <= rs1_adr_d;
      rs2_adr_q   <= rs2_adr_d;
      rd_adr_q    <= rd_adr_d;
      rs1_deger_q <= rs1_deger_d;
      rs2_deger_q <= rs2_deger_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      imm_sec_q   <= imm_sec_d;
      pc_sec_q    <= pc_sec_d;
      alu_dnt_q   <= alu_dnt_d;
      yaz_en_q    <= yaz_en_d;
      yukle_q     <= yukle_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_giris_asamasi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_giris_asamasi                                            |
// | Purpose  : Self-checking bench for alu_giris_asamasi. Expected EX-side     |
// |            outputs are queued when an instruction is driven and compared  |
// |            when it is handed to EX. ALU_YONLENDIRME_EN selects which       |
// |            intermediate (pre-release) values are expected.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_giris_asamasi;
  localparam int XLEN = 32;
`ifdef ALU_YONLENDIRME_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int VW = 4*XLEN + 4 + 5 + 2;

  logic            clk, rst_n, temizle;
  logic            id_gecerli, id_hazir;
  logic [4:0]      id_rs1_adr, id_rs2_adr, id_rd_adr;
  logic [XLEN-1:0] id_rs1_deger, id_rs2_deger, id_imm, id_pc;
  logic            id_imm_sec, id_pc_sec;
  logic [3:0]      id_alu_dnt;
  logic            id_yaz_en, id_yukle;
  logic            mem_yaz_en, mem_yukle;
  logic [4:0]      mem_rd_adr;
  logic [XLEN-1:0] mem_sonuc;
  logic            wb_yaz_en;
  logic [4:0]      wb_rd_adr;
  logic [XLEN-1:0] wb_sonuc;
  logic            ex_gecerli, ex_hazir;
  logic [XLEN-1:0] alu_a, alu_b, ex_rs2_deger, ex_pc;
  logic [3:0]      alu_dnt;
  logic [4:0]      ex_rd_adr;
  logic            ex_yaz_en, ex_yukle;

  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] got, want;

  alu_giris_asamasi #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .temizle(temizle),
    .id_gecerli(id_gecerli), .id_hazir(id_hazir),
    .id_rs1_adr(id_rs1_adr), .id_rs2_adr(id_rs2_adr), .id_rd_adr(id_rd_adr),
    .id_rs1_deger(id_rs1_deger), .id_rs2_deger(id_rs2_deger),
    .id_imm(id_imm), .id_pc(id_pc), .id_imm_sec(id_imm_sec), .id_pc_sec(id_pc_sec),
    .id_alu_dnt(id_alu_dnt), .id_yaz_en(id_yaz_en), .id_yukle(id_yukle),
    .mem_yaz_en(mem_yaz_en), .mem_rd_adr(mem_rd_adr), .mem_sonuc(mem_sonuc),
    .mem_yukle(mem_yukle), .wb_yaz_en(wb_yaz_en), .wb_rd_adr(wb_rd_adr),
    .wb_sonuc(wb_sonuc), .ex_gecerli(ex_gecerli), .ex_hazir(ex_hazir),
    .alu_a(alu_a), .alu_b(alu_b), .alu_dnt(alu_dnt), .ex_rs2_deger(ex_rs2_deger),
    .ex_rd_adr(ex_rd_adr), .ex_yaz_en(ex_yaz_en), .ex_yukle(ex_yukle), .ex_pc(ex_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [VW-1:0] obs();
    return {alu_a, alu_b, alu_dnt, ex_rs2_deger, ex_rd_adr, ex_yaz_en, ex_yukle, ex_pc};
  endfunction

  // Reference model of what EX should see for an instruction whose sources
  // end up holding v1/v2 by the time it issues.
  function automatic logic [VW-1:0] make_exp(
    input logic [4:0] a1, input logic [XLEN-1:0] v1,
    input logic [4:0] a2, input logic [XLEN-1:0] v2,
    input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
    input logic isec, input logic psec, input logic [3:0] dnt,
    input logic [4:0] rd, input logic yaz, input logic yuk);
    logic [XLEN-1:0] op1, op2;
    op1 = (a1 == 5'd0) ? '0 : v1;
    op2 = (a2 == 5'd0) ? '0 : v2;
    return {(psec ? pc : op1), (isec ? imm : op2), dnt, op2, rd, yaz, yuk, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(
    input logic [4:0] a1, input logic [XLEN-1:0] v1,
    input logic [4:0] a2, input logic [XLEN-1:0] v2,
    input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
    input logic isec, input logic psec, input logic [3:0] dnt,
    input logic [4:0] rd, input logic yaz, input logic yuk);
    id_gecerli   = 1'b1;
    id_rs1_adr   = a1;  id_rs1_deger = v1;
    id_rs2_adr   = a2;  id_rs2_deger = v2;
    id_imm       = imm; id_pc        = pc;
    id_imm_sec   = isec; id_pc_sec   = psec;
    id_alu_dnt   = dnt; id_rd_adr    = rd;
    id_yaz_en    = yaz; id_yukle     = yuk;
  endtask

  task automatic idle_id();
    drive_id(5'd0, '0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    id_gecerli = 1'b0;
  endtask

  task automatic idle_bypass();
    mem_yaz_en = 1'b0; mem_yukle = 1'b0; mem_rd_adr = 5'd0; mem_sonuc = '0;
    wb_yaz_en  = 1'b0; wb_rd_adr = 5'd0; wb_sonuc  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; temizle = 1'b0; ex_hazir = 1'b1;
    idle_id(); idle_bypass();
    tick();
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL reset_ex_gecerli: got %b want 0", ex_gecerli); end
    n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL reset_id_hazir: got %b want 1", id_hazir); end
    n_checks++; if (obs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    rst_n = 1'b1;
    tick();
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", ex_gecerli); end
  endtask

  task automatic test_basic();
    ex_hazir = 1'b1;
    drive_id(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h100, 1'b0, 1'b0, 4'b0000, 5'd8, 1'b1, 1'b0);
    sb.push_back(make_exp(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h100, 1'b0, 1'b0, 4'b0000, 5'd8, 1'b1, 1'b0));
    #2;
    n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", id_hazir); end
    tick(); idle_id();
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", ex_gecerli); end
    got = obs(); want = sb.pop_front();
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL basic_out: got %h want %h", got, want); end
    tick();
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", ex_gecerli); end
  endtask

  task automatic test_forward_priority();
    ex_hazir = 1'b0;
    drive_id(5'd3, 32'h33, 5'd9, 32'h44, 32'h10, 32'h200, 1'b1, 1'b0, 4'b0010, 5'd10, 1'b1, 1'b0);
    sb.push_back(make_exp(5'd3, 32'h22, 5'd9, 32'h44, 32'h10, 32'h200, 1'b1, 1'b0, 4'b0010, 5'd10, 1'b1, 1'b0));
    tick(); idle_id();
    mem_yaz_en = 1'b1; mem_rd_adr = 5'd3; mem_sonuc = 32'h11; mem_yukle = 1'b0;
    wb_yaz_en  = 1'b1; wb_rd_adr  = 5'd3; wb_sonuc  = 32'h22;
    #2;
    n_checks++; if (ex_gecerli !== FWD) begin n_fail++; $display("FAIL fwd_both_valid: got %b want %b", ex_gecerli, FWD); end
    n_checks++; if (alu_a !== (FWD ? 32'h11 : 32'h33)) begin n_fail++; $display("FAIL fwd_mem_prio: got %h want %h", alu_a, (FWD ? 32'h11 : 32'h33)); end
    n_checks++; if (id_hazir !== 1'b0) begin n_fail++; $display("FAIL fwd_held_ready: got %b want 0", id_hazir); end
    tick(); mem_yaz_en = 1'b0;
    #2;
    n_checks++; if (alu_a !== 32'h22) begin n_fail++; $display("FAIL fwd_wb_only: got %h want 22", alu_a); end
    n_checks++; if (ex_gecerli !== FWD) begin n_fail++; $display("FAIL fwd_wb_valid: got %b want %b", ex_gecerli, FWD); end
    tick(); wb_yaz_en = 1'b0;
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL fwd_release: got %b want 1", ex_gecerli); end
    ex_hazir = 1'b1;
    #1;
    got = obs(); want = sb.pop_front();
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL fwd_out: got %h want %h", got, want); end
    tick(); idle_bypass();
  endtask

  task automatic test_load_use();
    ex_hazir = 1'b1;
    drive_id(5'd1, 32'h1, 5'd4, 32'h4, 32'h0, 32'h300, 1'b0, 1'b0, 4'b0100, 5'd5, 1'b1, 1'b0);
    sb.push_back(make_exp(5'd1, 32'h1, 5'd4, 32'h55, 32'h0, 32'h300, 1'b0, 1'b0, 4'b0100, 5'd5, 1'b1, 1'b0));
    tick(); idle_id();
    mem_yaz_en = 1'b1; mem_yukle = 1'b1; mem_rd_adr = 5'd4; mem_sonuc = 32'hDEADBEEF;
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b want 0", ex_gecerli); end
    n_checks++; if (id_hazir !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_ready: got %b want 0", id_hazir); end
    tick();
    mem_yaz_en = 1'b0; mem_yukle = 1'b0;
    wb_yaz_en = 1'b1; wb_rd_adr = 5'd4; wb_sonuc = 32'h55;
    ex_hazir = 1'b0;
    #2;
    n_checks++; if (ex_gecerli !== FWD) begin n_fail++; $display("FAIL lu_after_valid: got %b want %b", ex_gecerli, FWD); end
    n_checks++; if (alu_b !== (FWD ? 32'h55 : 32'h4)) begin n_fail++; $display("FAIL lu_after_b: got %h want %h", alu_b, (FWD ? 32'h55 : 32'h4)); end
    tick(); wb_yaz_en = 1'b0; ex_hazir = 1'b1;
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", ex_gecerli); end
    got = obs(); want = sb.pop_front();
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL lu_out: got %h want %h", got, want); end
    tick(); idle_bypass();
  endtask

  task automatic test_backpressure();
    ex_hazir = 1'b0;
    drive_id(5'd6, 32'h60, 5'd2, 32'h20, 32'h0, 32'h400, 1'b0, 1'b0, 4'b1000, 5'd7, 1'b1, 1'b0);
    sb.push_back(make_exp(5'd6, 32'h99, 5'd2, 32'h20, 32'h0, 32'h400, 1'b0, 1'b0, 4'b1000, 5'd7, 1'b1, 1'b0));
    tick(); idle_id();
    wb_yaz_en = 1'b1; wb_rd_adr = 5'd6; wb_sonuc = 32'h99;
    #2;
    n_checks++; if (ex_gecerli !== FWD) begin n_fail++; $display("FAIL bp_c1_valid: got %b want %b", ex_gecerli, FWD); end
    n_checks++; if (alu_a !== (FWD ? 32'h99 : 32'h60)) begin n_fail++; $display("FAIL bp_c1_a: got %h want %h", alu_a, (FWD ? 32'h99 : 32'h60)); end
    tick(); wb_yaz_en = 1'b0; wb_sonuc = 32'h0;
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL bp_c2_valid: got %b want 1", ex_gecerli); end
    n_checks++; if (alu_a !== 32'h99) begin n_fail++; $display("FAIL bp_c2_a: got %h want 99", alu_a); end
    n_checks++; if (id_hazir !== 1'b0) begin n_fail++; $display("FAIL bp_c2_ready: got %b want 0", id_hazir); end
    tick();
    #2;
    n_checks++; if (alu_a !== 32'h99) begin n_fail++; $display("FAIL bp_c3_a: got %h want 99", alu_a); end
    tick(); ex_hazir = 1'b1;
    #2;
    n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL bp_c4_ready: got %b want 1", id_hazir); end
    got = obs(); want = sb.pop_front();
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL bp_out: got %h want %h", got, want); end
    tick(); idle_bypass();
  endtask

  task automatic test_flush();
    ex_hazir = 1'b0;
    drive_id(5'd1, 32'hA1, 5'd2, 32'hA2, 32'h0, 32'h500, 1'b0, 1'b0, 4'b0001, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(5'd4, 32'hB1, 5'd5, 32'hB2, 32'h0, 32'h504, 1'b0, 1'b0, 4'b0001, 5'd6, 1'b1, 1'b0);
    temizle = 1'b1;
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL flush_held_valid: got %b want 1", ex_gecerli); end
    tick(); temizle = 1'b0; idle_id();
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL flush_held_gone: got %b want 0", ex_gecerli); end
    n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", id_hazir); end
    // flush racing a capture into an empty stage
    drive_id(5'd7, 32'hC1, 5'd8, 32'hC2, 32'h0, 32'h508, 1'b0, 1'b0, 4'b0001, 5'd9, 1'b1, 1'b0);
    temizle = 1'b1;
    tick(); temizle = 1'b0; idle_id();
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL flush_capture: got %b want 0", ex_gecerli); end
    ex_hazir = 1'b1;
  endtask

  task automatic test_x0();
    ex_hazir = 1'b0;
    drive_id(5'd0, 32'h0, 5'd7, 32'h70, 32'h0, 32'h600, 1'b0, 1'b0, 4'b0011, 5'd9, 1'b1, 1'b0);
    sb.push_back(make_exp(5'd0, 32'h0, 5'd7, 32'h70, 32'h0, 32'h600, 1'b0, 1'b0, 4'b0011, 5'd9, 1'b1, 1'b0));
    tick(); idle_id();
    mem_yaz_en = 1'b1; mem_yukle = 1'b1; mem_rd_adr = 5'd0; mem_sonuc = 32'hBAD;
    wb_yaz_en  = 1'b1; wb_rd_adr = 5'd0; wb_sonuc = 32'hBAD2;
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall: got %b want 1", ex_gecerli); end
    n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL x0_load_a: got %h want 0", alu_a); end
    tick(); mem_yukle = 1'b0;
    #2;
    n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL x0_fwd_a: got %h want 0", alu_a); end
    ex_hazir = 1'b1;
    #1;
    got = obs(); want = sb.pop_front();
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL x0_out: got %h want %h", got, want); end
    tick(); idle_bypass();
  endtask

  task automatic test_back_to_back();
    logic [4:0]      a1, a2, rd;
    logic [XLEN-1:0] v1, v2, imm, pc;
    logic            isec, psec;
    logic [3:0]      dnt;
    ex_hazir = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        a1 = 5'(i + 1); a2 = 5'(i + 20); rd = 5'(i + 11);
        v1 = $urandom; v2 = $urandom; imm = $urandom; pc = 32'h1000 + 32'(i * 4);
        isec = (i % 2) == 1; psec = (i % 4) >= 2; dnt = 4'(i * 3);
        drive_id(a1, v1, a2, v2, imm, pc, isec, psec, dnt, rd, 1'b1, (i == 3));
        sb.push_back(make_exp(a1, v1, a2, v2, imm, pc, isec, psec, dnt, rd, 1'b1, (i == 3)));
      end else begin
        idle_id();
      end
      #2;
      n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, id_hazir); end
      if (i > 0) begin
        n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ex_gecerli); end
        got = obs(); want = sb.pop_front();
        n_checks++; if (got !== want) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", i, got, want); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ex_hazir = 1'b0;
    drive_id(5'd1, 32'h77, 5'd2, 32'h88, 32'h0, 32'h700, 1'b0, 1'b0, 4'b0101, 5'd4, 1'b1, 1'b0);
    tick(); idle_id();
    #2;
    n_checks++; if (ex_gecerli !== 1'b1) begin n_fail++; $display("FAIL arst_before: got %b want 1", ex_gecerli); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", ex_gecerli); end
    n_checks++; if (id_hazir !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", id_hazir); end
    n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL arst_a: got %h want 0", alu_a); end
    tick(); rst_n = 1'b1; ex_hazir = 1'b1;
    tick();
    #2;
    n_checks++; if (ex_gecerli !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b want 0", ex_gecerli); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_x0();
    test_back_to_back();
    test_async_reset();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
